counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
//
// PURPOSE
// Shares one counter instance (clk/reset/enable/count, WIDTH-bit) between NREQ requesters.
// Each requester asks for a counting window of req_len enabled cycles. The arbiter grants
// requesters round-robin, clears the counter, enables it for exactly that many cycles,
// then returns the final count with a one-cycle done pulse. Sits between the requesters
// and the counter; it owns the counter's enable and reset pins exclusively.
//
// PARAMETERS
// WIDTH   8   counter width; width of ctr_count and result
// NREQ    4   number of requesters (>=2)
// LEN_W   8   width of each requested window length
//
// PORTS
// clk        in   1            clock; all logic on rising edge
// reset      in   1            asynchronous, active-low reset (0 = reset)
// req        in   NREQ         request per requester; held high until its done pulse
// req_len    in   NREQ*LEN_W   window length per requester, slice i = [i*LEN_W +: LEN_W]
// grant      out  NREQ         one-hot grant, registered
// done       out  NREQ         one-cycle pulse to granted requester; result valid same cycle
// result     out  WIDTH        final counter value of last completed window
// busy       out  1            high whenever state != IDLE
// ctr_enable out  1            drives counter enable
// ctr_clear  out  1            drives counter reset (active-high on counter side)
// ctr_count  in   WIDTH        counter count output
//
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE, grant=0, done=0, result=0, busy=0, ctr_enable=0,
//   ctr_clear=0, rr pointer so req[0] has highest priority. Reset mid-window aborts it;
//   no done pulse; the counter keeps its value (next window clears it anyway).
// - All outputs registered. FSM: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
// - IDLE: if any req, pick first set bit searching from (last_granted+1) mod NREQ upward;
//   latch its req_len into remaining; grant<=onehot; busy<=1; ->CLEAR. No req: stay.
// - CLEAR (1 cycle): ctr_clear=1, ctr_enable=0. If latched len==0 ->DONE, else ->RUN.
// - RUN: ctr_enable=1 for exactly len cycles (remaining decrements each cycle); after the
//   len-th cycle ->DONE with ctr_enable=0. Counter therefore sees exactly len enabled edges.
// - DONE (1 cycle): ctr_enable=0; result<=ctr_count; done[g]<=1; grant<=0; busy<=0; ->IDLE.
//   Hence done/result/grant-drop appear together in the first IDLE cycle after DONE.
// - Timing: req seen in IDLE at cycle t -> grant high t+1..t+len+2, ctr_clear at t+1,
//   ctr_enable t+2..t+len+1, done pulse + result valid at t+len+3. len=0: done at t+3.
// - Abort: if req[g] drops during CLEAR or RUN, next cycle ctr_enable=0, grant=0, busy=0,
//   ->IDLE; no done, result unchanged; rr pointer still advances past g.
// - req_len sampled only in IDLE; later changes ignored. Other reqs ignored while busy.
// - Width: result = len mod 2^WIDTH (counter wraps); LEN_W may exceed WIDTH.
// - Requester still asserting req in the done cycle is re-eligible, but behind all others.
// - Earliest new grant is the cycle after done (one IDLE cycle between windows).
//
// TESTING
// 1 Reset: hold reset=0 with req=4'b1111 -> all outputs 0; release -> grant=0001 next cycle.
// 2 Single: req[2]=1, len=5 -> ctr_clear 1 cycle, ctr_enable exactly 5 cycles, done=0100
//   at t+8, result=5, grant drops same cycle.
// 3 Round-robin: req=1111 all len=3, hold -> grants 0001,0010,0100,1000,0001; results all 3.
// 4 Boundary: len=0 -> no ctr_enable, done at t+3, result=0; WIDTH=8, len=255 -> 255;
//   LEN_W=10, len=300 -> result=44.
// 5 Abort: req[1] len=10, drop req[1] after 4 RUN cycles -> enable low next cycle, no
//   done, result keeps previous value, next grant goes to req[2] if pending.
// 6 Mid-run reset: assert reset=0 during RUN -> outputs 0 immediately; after release a
//   new len=4 window yields result=4 (counter cleared by CLEAR state).

Source files
------------

// File: rtl/counter_arbiter.sv
// ---------------------------------------------------------------------------
// counter_arbiter
//
// Purpose:
//   Shares one external counter between NREQ requesters. Each requester asks
//   for a counting window of req_len enabled cycles. Requests are granted
//   round-robin. For each window the arbiter clears the counter, enables it
//   for exactly the latched length, and then hands back the final count.
//   The result comes with a one-cycle done pulse to the requester that owned
//   the window. The arbiter is the only driver of the counter's enable and
//   clear pins.
//
// Parameters:
//   WIDTH  counter width; width of ctr_count and result
//   NREQ   number of requesters (>= 2)
//   LEN_W  width of each requested window length
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous reset, active low
//   req         in   [NREQ]        request per requester, held until its done
//   req_len     in   [NREQ*LEN_W]  window length, slice i = [i*LEN_W +: LEN_W]
//   grant       out  [NREQ]        one-hot owner of the current window
//   done        out  [NREQ]        one-cycle completion pulse to the owner
//   result      out  [WIDTH]       final count of the last completed window
//   busy        out                high while a window is in progress
//   ctr_enable  out                counter enable
//   ctr_clear   out                counter clear (active high)
//   ctr_count   in   [WIDTH]       counter value
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module counter_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  ctr_enable,
    output logic                  ctr_clear,
    input  logic [WIDTH-1:0]      ctr_count
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_reg,     state_next;
    logic [NREQ-1:0]    grant_reg,     grant_next;
    logic [NREQ-1:0]    done_reg,      done_next;
    logic [WIDTH-1:0]   result_reg,    result_next;
    logic               busy_reg,      busy_next;
    logic               enable_reg,    enable_next;
    logic               clear_reg,     clear_next;
    logic [LEN_W-1:0]   remaining_reg, remaining_next;
    logic [IDX_W-1:0]   owner_reg,     owner_next;
    // Index of the most recent grant. The round-robin search starts one past it.
    logic [IDX_W-1:0]   last_reg,      last_next;

    // ------------------------------------------------------------------
    // Per-requester length slices
    // ------------------------------------------------------------------
    logic [LEN_W-1:0]   len_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_slice[gi] = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick
    // Walk the requesters starting at last_reg+1 and wrap at NREQ. The first
    // requester that is asking wins. The start offset is at most NREQ-1 and
    // the step is at most NREQ-1, so one conditional subtract is enough to
    // wrap the index.
    // ------------------------------------------------------------------
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NREQ-1:0]    pick_onehot;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(last_reg) + 1 + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = pick_valid && (pick_idx == IDX_W'(gi));
        end
    endgenerate

    // The owner withdrawing its request cancels the window.
    logic owner_req;
    assign owner_req = req[owner_reg];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            done_reg      <= '0;
            result_reg    <= '0;
            busy_reg      <= 1'b0;
            enable_reg    <= 1'b0;
            clear_reg     <= 1'b0;
            remaining_reg <= '0;
            owner_reg     <= '0;
            // Start from the top index so that req[0] has first priority.
            last_reg      <= IDX_W'(NREQ-1);
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            result_reg    <= result_next;
            busy_reg      <= busy_next;
            enable_reg    <= enable_next;
            clear_reg     <= clear_next;
            remaining_reg <= remaining_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // Each _next value is what the matching output shows in the next cycle.
    // So enable_next is raised while leaving CLEAR and dropped on the last
    // RUN cycle. That gives exactly remaining_reg enabled counter edges.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        done_next      = '0;
        result_next    = result_reg;
        busy_next      = busy_reg;
        enable_next    = enable_reg;
        clear_next     = 1'b0;
        remaining_next = remaining_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;

        case (state_reg)
            IDLE: begin
                enable_next = 1'b0;
                if (pick_valid) begin
                    state_next     = CLEAR;
                    grant_next     = pick_onehot;
                    owner_next     = pick_idx;
                    last_next      = pick_idx;
                    remaining_next = len_slice[pick_idx];
                    busy_next      = 1'b1;
                    clear_next     = 1'b1;
                end
            end

            CLEAR: begin
                if (!owner_req) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    busy_next   = 1'b0;
                    enable_next = 1'b0;
                end else if (remaining_reg == '0) begin
                    state_next  = DONE;
                    enable_next = 1'b0;
                end else begin
                    state_next  = RUN;
                    enable_next = 1'b1;
                end
            end

            RUN: begin
                if (!owner_req) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    busy_next   = 1'b0;
                    enable_next = 1'b0;
                end else begin
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next  = DONE;
                        enable_next = 1'b0;
                    end
                end
            end

            DONE: begin
                // The counter took its last enabled edge on entry to DONE,
                // so ctr_count is final here.
                state_next  = IDLE;
                result_next = ctr_count;
                done_next   = grant_reg;
                grant_next  = '0;
                busy_next   = 1'b0;
                enable_next = 1'b0;
            end

            default: begin
                state_next  = IDLE;
                grant_next  = '0;
                busy_next   = 1'b0;
                enable_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant      = grant_reg;
    assign done       = done_reg;
    assign result     = result_reg;
    assign busy       = busy_reg;
    assign ctr_enable = enable_reg;
    assign ctr_clear  = clear_reg;

endmodule

// File: tb/tb_counter_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_arbiter
//
// Self-checking bench for counter_arbiter. A simple counter with a
// synchronous clear is modelled here and wired to the arbiter's counter pins.
// LEN_W is 10 so that windows longer than the 8-bit counter range can be
// requested.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_counter_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int LEN_W = 10;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [LEN_W-1:0]      len_arr [NREQ];
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic                  ctr_enable;
    logic                  ctr_clear;
    logic [WIDTH-1:0]      cnt = 8'h5A;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_len[i*LEN_W +: LEN_W] = len_arr[i];
        end
    end

    // Shared counter: synchronous active-high clear, count when enabled.
    always @(posedge clk) begin
        if (ctr_clear)       cnt <= '0;
        else if (ctr_enable) cnt <= cnt + 1'b1;
    end

    counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_len    (req_len),
        .grant      (grant),
        .done       (done),
        .result     (result),
        .busy       (busy),
        .ctr_enable (ctr_enable),
        .ctr_clear  (ctr_clear),
        .ctr_count  (cnt)
    );

    typedef struct {
        int         idx;
        int         len;
        int         exp_result;
        logic [3:0] exp_done;
        int         exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference round-robin choice: the first asking requester after 'last', with wrap-around.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[2'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) len_arr[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  32'(grant),      0);
        check({tag, "_done"},   32'(done),       0);
        check({tag, "_result"}, 32'(result),     0);
        check({tag, "_busy"},   32'(busy),       0);
        check({tag, "_enable"}, 32'(ctr_enable), 0);
        check({tag, "_clear"},  32'(ctr_clear),  0);
    endtask

    // Run one isolated window for requester idx. Measure latency and activity.
    // This task is called at a falling edge, and that cycle counts as cycle t.
    task automatic run_window(input int idx, input int len, input int exp_res,
                              input logic [3:0] exp_done, input int exp_lat);
        int k;
        int g = 0, b = 0, e = 0, c = 0, cbad = 0;
        logic [3:0] oh;
        logic [3:0] done_seen = '0;
        logic [3:0] grant_at_done = '1;
        logic [WIDTH-1:0] res = '1;
        oh = 4'(1) << idx;
        len_arr[2'(idx)] = LEN_W'(len);
        req[2'(idx)] = 1'b1;
        for (k = 1; k <= len + 10; k++) begin
            @(negedge clk);
            if (grant == oh) g++;
            if (busy) b++;
            if (ctr_enable) e++;
            if (ctr_clear) begin
                c++;
                if (k != 1) cbad++;
            end
            if (done != 0) begin
                done_seen     = done;
                grant_at_done = grant;
                res           = result;
                break;
            end
        end
        check($sformatf("win%0d_len%0d_latency", idx, len), 32'(k), 32'(exp_lat));
        check($sformatf("win%0d_len%0d_done", idx, len), 32'(done_seen), 32'(exp_done));
        check($sformatf("win%0d_len%0d_result", idx, len), 32'(res), 32'(exp_res));
        check($sformatf("win%0d_len%0d_grant_drop", idx, len), 32'(grant_at_done), 0);
        check($sformatf("win%0d_len%0d_enable_cycles", idx, len), 32'(e), 32'(len));
        check($sformatf("win%0d_len%0d_clear_cycles", idx, len), 32'(c), 1);
        check($sformatf("win%0d_len%0d_clear_late", idx, len), 32'(cbad), 0);
        check($sformatf("win%0d_len%0d_grant_cycles", idx, len), 32'(g), 32'(len + 2));
        check($sformatf("win%0d_len%0d_busy_cycles", idx, len), 32'(b), 32'(len + 2));
        req[2'(idx)] = 1'b0;
        len_arr[2'(idx)] = '0;
        $display("window req=%0d len=%0d done=%b result=%0d latency=%0d", idx, len, done_seen, res, k);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < NREQ; i++) len_arr[i] = LEN_W'(3);
        repeat (3) @(negedge clk);
        check_all_zero("reset_hold");
        reset = 1'b1;
        @(negedge clk);
        check("reset_first_grant", 32'(grant), 32'(4'b0001));
        check("reset_first_busy", 32'(busy), 1);
        check("reset_first_clear", 32'(ctr_clear), 1);
        // Drop all requests during CLEAR: the window is abandoned.
        req = '0;
        @(negedge clk);
        check("clear_abort_grant", 32'(grant), 0);
        check("clear_abort_busy", 32'(busy), 0);
        check("clear_abort_enable", 32'(ctr_enable), 0);
        check("clear_abort_done", 32'(done), 0);
        $display("reset sequence finished");
    endtask

    task automatic test_table();
        vec_t vecs[6];
        vecs[0] = '{2, 5,   5,   4'b0100, 8};
        vecs[1] = '{0, 0,   0,   4'b0001, 3};
        vecs[2] = '{3, 255, 255, 4'b1000, 258};
        vecs[3] = '{1, 300, 44,  4'b0010, 303};
        vecs[4] = '{0, 1,   1,   4'b0001, 4};
        vecs[5] = '{3, 256, 0,   4'b1000, 259};
        for (int i = 0; i < 6; i++) begin
            run_window(vecs[i].idx, vecs[i].len, vecs[i].exp_result, vecs[i].exp_done, vecs[i].exp_lat);
        end
    endtask

    task automatic test_rr();
        int last = NREQ - 1;
        int n = 0;
        int prev_k = 0;
        int exp_i;
        do_reset();
        for (int i = 0; i < NREQ; i++) len_arr[i] = LEN_W'(3);
        req = 4'b1111;
        for (int k = 1; k <= 200 && n < 5; k++) begin
            @(negedge clk);
            if (done != 0) begin
                exp_i = rr_pick(4'b1111, last);
                check($sformatf("rr%0d_done", n), 32'(done), 32'(4'(1) << exp_i));
                check($sformatf("rr%0d_result", n), 32'(result), 3);
                if (n > 0) check($sformatf("rr%0d_spacing", n), 32'(k - prev_k), 6);
                $display("rr window %0d done=%b result=%0d cycle=%0d", n, done, result, k);
                prev_k = k;
                last   = exp_i;
                n++;
            end
        end
        check("rr_windows", 32'(n), 5);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int en = 0;
        do_reset();
        run_window(0, 7, 7, 4'b0001, 10);
        len_arr[1] = LEN_W'(10);
        len_arr[2] = LEN_W'(2);
        req[1] = 1'b1;
        req[2] = 1'b1;
        for (int k = 0; k < 30 && en < 4; k++) begin
            @(negedge clk);
            if (ctr_enable) en++;
        end
        check("abort_run_cycles", 32'(en), 4);
        check("abort_owner", 32'(grant), 32'(4'b0010));
        req[1] = 1'b0;
        @(negedge clk);
        check("abort_enable", 32'(ctr_enable), 0);
        check("abort_grant", 32'(grant), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result_kept", 32'(result), 7);
        @(negedge clk);
        check("abort_next_grant", 32'(grant), 32'(4'b0100));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done != 0) break;
        end
        check("abort_next_done", 32'(done), 32'(4'b0100));
        check("abort_next_result", 32'(result), 2);
        $display("abort sequence: follow-up done=%b result=%0d", done, result);
        req[2] = 1'b0;
        len_arr[1] = '0;
        len_arr[2] = '0;
    endtask

    task automatic test_midrun_reset();
        len_arr[3] = LEN_W'(20);
        req[3] = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        req = '0;
        len_arr[3] = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_window(0, 4, 4, 4'b0001, 7);
    endtask

    function automatic int rand_len();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(250, 300));
        return int'($urandom_range(0, 12));
    endfunction

    task automatic test_random();
        int  last = NREQ - 1;
        bit  active = 1'b0;
        bit  expect_grant = 1'b0;
        int  exp_idx = 0;
        int  exp_len = 0;
        int  cyc = 0;
        int  windows = 0;
        int  wait_c [NREQ];
        logic [NREQ-1:0] exp_oh;
        do_reset();
        for (int i = 0; i < NREQ; i++) wait_c[i] = int'($urandom_range(0, 3));
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            // The req/len values still held are the ones the last rising edge sampled.
            if (expect_grant) check("rand_grant_follows_idle", 32'(grant != 0), 1);
            check("rand_busy", 32'(busy), 32'(grant != 0));
            if (!active && grant != 0) begin
                exp_idx = rr_pick(req, last);
                exp_oh  = (exp_idx < 0) ? '0 : (4'(1) << exp_idx);
                check("rand_grant", 32'(grant), 32'(exp_oh));
                exp_len = (exp_idx < 0) ? 0 : int'(len_arr[2'(exp_idx)]);
                last    = (exp_idx < 0) ? last : exp_idx;
                cyc     = 0;
                active  = 1'b1;
            end else if (active) begin
                cyc++;
                if (done != 0) begin
                    check("rand_done", 32'(done), 32'(exp_oh));
                    check("rand_result", 32'(result), 32'(exp_len % (1 << WIDTH)));
                    check("rand_latency", 32'(cyc), 32'(exp_len + 2));
                    $display("random window %0d req=%0d len=%0d result=%0d", windows, exp_idx, exp_len, result);
                    active = 1'b0;
                    windows++;
                end else if (cyc > exp_len + 2) begin
                    check("rand_window_timeout", 32'(cyc), 32'(exp_len + 2));
                    active = 1'b0;
                end
            end else if (done != 0) begin
                check("rand_spurious_done", 32'(done), 0);
            end
            // Drive the next cycle's requests.
            for (int i = 0; i < NREQ; i++) begin
                if (done[2'(i)]) begin
                    req[2'(i)] = 1'b0;
                    wait_c[i]  = int'($urandom_range(0, 3));
                end else if (!req[2'(i)]) begin
                    if (wait_c[i] == 0) begin
                        len_arr[2'(i)] = LEN_W'(rand_len());
                        req[2'(i)]     = 1'b1;
                    end else begin
                        wait_c[i]--;
                    end
                end else if (active && i == exp_idx) begin
                    // The owner's length is latched, so scribbling on it must not matter.
                    len_arr[2'(i)] = LEN_W'($urandom_range(0, 1023));
                end
            end
            expect_grant = (grant == 0) && (req != 0);
        end
        check("rand_window_count_min", 32'(windows > 20), 1);
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) len_arr[i] = '0;
        test_reset();
        test_table();
        test_rr();
        test_abort();
        test_midrun_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
